// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the wait-state Hack CPU core:
//   - instruction field positions for the C-instruction
//   - core state enum (EXEC / WRITE)
//   - jump-condition helper used at commit
// -----------------------------------------------------------------------------
package hack_pkg;

  // C-instruction field positions, counted from bit 0 of I.
  localparam int A_BIT = 12;  // a: ALU y operand is M (1) or A (0)
  localparam int C_LSB = 6;   // c: zx nx zy ny f no, in I[11:6]
  localparam int D_LSB = 3;   // d: A D M, in I[5:3]

  // Destination bit positions inside the 3-bit d field.
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;

  typedef enum logic {
    EXEC  = 1'b0,  // decode / execute / commit
    WRITE = 1'b1   // committed instruction waits for its M write
  } cpuState_t;

  // j = {lt, eq, gt}. Exactly one of ng / zr / positive holds, so
  // j=111 always jumps without a special case.
  function automatic logic jumpTaken(input logic [2:0] j,
                                     input logic       zr,
                                     input logic       ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// -----------------------------------------------------------------------------
// hack_alu
// Combinational Hack ALU, WIDTH-bit two's complement, carry discarded.
// Ports:
//   x      in  WIDTH  first operand (D register)
//   y      in  WIDTH  second operand (A register or inM)
//   ctrl   in  6      {zx, nx, zy, ny, f, no}
//   result out WIDTH  ALU output
//   zr     out 1      result == 0
//   ng     out 1      result is negative (MSB set)
// -----------------------------------------------------------------------------
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] xZero;
  logic [WIDTH-1:0] xNeg;
  logic [WIDTH-1:0] yZero;
  logic [WIDTH-1:0] yNeg;
  logic [WIDTH-1:0] fOut;

  always_comb begin
    xZero  = ctrl[5] ? '0 : x;
    xNeg   = ctrl[4] ? ~xZero : xZero;
    yZero  = ctrl[3] ? '0 : y;
    yNeg   = ctrl[2] ? ~yZero : yZero;
    fOut   = ctrl[1] ? (xNeg + yNeg) : (xNeg & yNeg);
    result = ctrl[0] ? ~fOut : fOut;
    zr     = (result == '0);
    ng     = result[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu_ws.sv
// -----------------------------------------------------------------------------
// hack_cpu_ws
// Parametrised Hack CPU core with a wait-state data-memory handshake, an
// instruction-valid fetch stall and a retired-instruction counter.
//
// Ports:
//   clock        in  1       system clock, rising edge
//   reset        in  1       synchronous, active-high
//   I            in  WIDTH   instruction at pc
//   instr_valid  in  1       I is valid this cycle
//   inM          in  WIDTH   data read from addressM
//   mem_ready    in  1       data memory completes current read/write
//   outM         out WIDTH   write data (registered)
//   writeM       out 1       write request (registered)
//   readM        out 1       read request (combinational)
//   addressM     out ADDR_W  data address
//   pc           out ADDR_W  fetch address (registered)
//   retire       out 1       one-cycle pulse per committed instruction
//   instret      out WIDTH   committed-instruction count, wraps
//
// An instruction commits in EXEC in a single edge. If it writes M, the core
// then parks in WRITE holding writeM/addressM until mem_ready, without
// consuming the next instruction.
// -----------------------------------------------------------------------------
module hack_cpu_ws
  import hack_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int RESET_PC = 0,
  localparam int ADDR_W   = WIDTH - 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  I,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  inM,
  input  logic              mem_ready,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic              readM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic [WIDTH-1:0]  instret
);

  cpuState_t        state;
  cpuState_t        stateNext;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] dReg;
  logic [ADDR_W-1:0] addrQ;

  // Decode. Bits I[WIDTH-2:13] of a C-instruction are simply never looked at.
  logic       isC;
  logic       aSel;
  logic [5:0] aluCtrl;
  logic [2:0] dest;
  logic [2:0] jmp;
  logic       needRead;

  assign isC      = I[WIDTH-1];
  assign aSel     = I[A_BIT];
  assign aluCtrl  = I[C_LSB +: 6];
  assign dest     = I[D_LSB +: 3];
  assign jmp      = I[2:0];
  assign needRead = isC & aSel;

  // ALU: x = D, y = M or A.
  logic [WIDTH-1:0] aluY;
  logic [WIDTH-1:0] aluOut;
  logic             aluZr;
  logic             aluNg;

  assign aluY = aSel ? inM : aReg;

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x      (dReg),
    .y      (aluY),
    .ctrl   (aluCtrl),
    .result (aluOut),
    .zr     (aluZr),
    .ng     (aluNg)
  );

  logic commit;
  logic jump;

  assign jump = isC & jumpTaken(jmp, aluZr, aluNg);

  // ---------------------------------------------------------------------------
  // State register plus all datapath registers.
  // NOTE: every sequential assignment is non-blocking so that all registers
  // sample the pre-edge values (jump target and addrQ use the old A).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= EXEC;
      aReg    <= '0;
      dReg    <= '0;
      pc      <= ADDR_W'(RESET_PC);
      outM    <= '0;
      writeM  <= 1'b0;
      addrQ   <= '0;
      retire  <= 1'b0;
      instret <= '0;
    end else begin
      state  <= stateNext;
      retire <= commit;
      if (commit) begin
        instret <= instret + WIDTH'(1);
        pc      <= jump ? aReg[ADDR_W-1:0] : pc + ADDR_W'(1);
        if (!isC) begin
          aReg <= {1'b0, I[WIDTH-2:0]};
        end else begin
          if (dest[DEST_A]) aReg <= aluOut;
          if (dest[DEST_D]) dReg <= aluOut;
          if (dest[DEST_M]) begin
            outM   <= aluOut;
            addrQ  <= aReg[ADDR_W-1:0];
            writeM <= 1'b1;
          end
        end
      end else if (state == WRITE && mem_ready) begin
        writeM <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      EXEC:  if (commit && isC && dest[DEST_M]) stateNext = WRITE;
      WRITE: if (mem_ready)                     stateNext = EXEC;
      default: stateNext = EXEC;
    endcase
  end

  // Output / handshake logic.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    readM    = 1'b0;
    commit   = 1'b0;
    addressM = aReg[ADDR_W-1:0];
    unique case (state)
      EXEC: begin
        readM  = instr_valid & needRead;
        commit = instr_valid & (~needRead | mem_ready);
      end
      WRITE: begin
        addressM = addrQ;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hack_cpu_ws.sv
// -----------------------------------------------------------------------------
// tb_hack_cpu_ws
// Directed-vector bench for hack_cpu_ws: a WIDTH=16 instance for the main
// sequences and a WIDTH=32 instance for the wide-datapath sequence.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_hack_cpu_ws;

  // ALU control codes {zx nx zy ny f no}
  localparam logic [5:0] C_ZERO   = 6'b101010;
  localparam logic [5:0] C_NEG1   = 6'b111010;
  localparam logic [5:0] C_D      = 6'b001100;
  localparam logic [5:0] C_A      = 6'b110000;
  localparam logic [5:0] C_APLUS1 = 6'b110111;
  localparam logic [5:0] C_DPLUSA = 6'b000010;
  localparam logic [5:0] C_AMIND  = 6'b000111;
  // destinations {A D M}
  localparam logic [2:0] D_NONE = 3'b000;
  localparam logic [2:0] D_A    = 3'b100;
  localparam logic [2:0] D_D    = 3'b010;
  localparam logic [2:0] D_M    = 3'b001;
  // jumps {lt eq gt}
  localparam logic [2:0] J_NO  = 3'b000;
  localparam logic [2:0] J_GT  = 3'b001;
  localparam logic [2:0] J_EQ  = 3'b010;
  localparam logic [2:0] J_LT  = 3'b100;
  localparam logic [2:0] J_MP  = 3'b111;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // WIDTH=16 instance
  logic        rst16, iv16, rdy16;
  logic [15:0] i16, inM16;
  logic [15:0] outM16, instret16;
  logic        wM16, rM16, ret16;
  logic [14:0] addr16, pc16;

  hack_cpu_ws #(.WIDTH(16), .RESET_PC(0)) dut16 (
    .clock(clock), .reset(rst16), .I(i16), .instr_valid(iv16), .inM(inM16),
    .mem_ready(rdy16), .outM(outM16), .writeM(wM16), .readM(rM16),
    .addressM(addr16), .pc(pc16), .retire(ret16), .instret(instret16)
  );

  // WIDTH=32 instance
  logic        rst32, iv32, rdy32;
  logic [31:0] i32, inM32;
  logic [31:0] outM32, instret32;
  logic        wM32, rM32, ret32;
  logic [30:0] addr32, pc32;

  hack_cpu_ws #(.WIDTH(32), .RESET_PC(0)) dut32 (
    .clock(clock), .reset(rst32), .I(i32), .instr_valid(iv32), .inM(inM32),
    .mem_ready(rdy32), .outM(outM32), .writeM(wM32), .readM(rM32),
    .addressM(addr32), .pc(pc32), .retire(ret32), .instret(instret32)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] c16(input logic a, input logic [5:0] comp,
                                      input logic [2:0] d, input logic [2:0] j);
    return {3'b111, a, comp, d, j};
  endfunction

  function automatic logic [31:0] c32(input logic a, input logic [5:0] comp,
                                      input logic [2:0] d, input logic [2:0] j);
    return {16'h8000, c16(a, comp, d, j)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exec16(input logic [15:0] ins);
    i16 = ins; iv16 = 1'b1; rdy16 = 1'b1;
    step();
  endtask

  task automatic exec32(input logic [31:0] ins);
    i32 = ins; iv32 = 1'b1; rdy32 = 1'b1;
    step();
  endtask

  logic sawW;

  initial begin
    rst16 = 1'b1; iv16 = 1'b0; rdy16 = 1'b1; i16 = '0; inM16 = '0;
    rst32 = 1'b1; iv32 = 1'b0; rdy32 = 1'b1; i32 = '0; inM32 = '0;
    step(); step();
    check("rst pc",      pc16,      0);
    check("rst instret", instret16, 0);
    check("rst writeM",  wM16,      0);
    check("rst retire",  ret16,     0);
    check("rst outM",    outM16,    0);
    rst16 = 1'b0;

    // 1: @12345, D=A, @23456, D=A-D -> D=11111
    sawW = 1'b0;
    exec16(16'd12345);                 sawW |= wM16;
    check("t1 retire", ret16, 1);
    exec16(c16(0, C_A, D_D, J_NO));    sawW |= wM16;
    exec16(16'd23456);                 sawW |= wM16;
    exec16(c16(0, C_AMIND, D_D, J_NO)); sawW |= wM16;
    check("t1 pc",      pc16,      4);
    check("t1 instret", instret16, 4);
    check("t1 no write", sawW,     0);
    exec16(c16(0, C_D, D_M, J_NO));    // M=D exposes D
    check("t1 writeM", wM16,   1);
    check("t1 D",      outM16, 11111);
    check("t1 addrM",  addr16, 23456);
    step();                            // write completes (mem_ready=1)
    check("t1 write done", wM16, 0);
    check("t1 pc hold",    pc16, 5);

    // 2: conditional jumps
    exec16(c16(0, C_ZERO, D_D, J_NO));
    exec16(16'd100);
    exec16(c16(0, C_D, D_NONE, J_EQ));
    check("t2 JEQ taken", pc16, 100);
    exec16(c16(0, C_NEG1, D_D, J_NO));
    exec16(c16(0, C_D, D_NONE, J_GT));
    check("t2 JGT not taken", pc16, 102);
    exec16(c16(0, C_D, D_NONE, J_LT));
    check("t2 JLT taken", pc16, 100);
    exec16(16'd50);
    exec16(c16(0, C_ZERO, D_NONE, J_MP));
    check("t2 JMP", pc16, 50);
    check("t2 instret", instret16, 13);

    // 3: D=M with three wait cycles
    exec16(16'd7);
    i16 = c16(1, C_A, D_D, J_NO); iv16 = 1'b1; rdy16 = 1'b0; inM16 = 16'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3 readM wait", rM16, 1);
      check("t3 addrM",      addr16, 7);
      step();
      check("t3 no retire", ret16, 0);
      check("t3 pc stall",  pc16,  51);
    end
    rdy16 = 1'b1; inM16 = 16'd42;
    #1;
    check("t3 readM last", rM16, 1);
    step();
    check("t3 retire", ret16, 1);
    check("t3 pc",     pc16,  52);
    iv16 = 1'b0;
    #1;
    check("t3 readM idle", rM16, 0);
    step();
    check("t3 retire pulse", ret16, 0);
    check("t3 pc idle",      pc16,  52);
    exec16(c16(0, C_D, D_M, J_NO));
    check("t3 D=42", outM16, 42);
    step();

    // 4: M=M+1, write ready after two wait cycles
    exec16(16'd7);
    i16 = c16(1, C_APLUS1, D_M, J_NO); inM16 = 16'd9; rdy16 = 1'b1;
    #1;
    check("t4 readM", rM16, 1);
    step();
    check("t4 writeM", wM16,   1);
    check("t4 addrM",  addr16, 7);
    check("t4 outM",   outM16, 10);
    check("t4 pc",     pc16,   55);
    rdy16 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4 no read in WRITE", rM16, 0);
      step();
      check("t4 writeM held", wM16,   1);
      check("t4 addrM held",  addr16, 7);
      check("t4 pc held",     pc16,   55);
      check("t4 no retire",   ret16,  0);
    end
    rdy16 = 1'b1;
    step();
    check("t4 write done", wM16, 0);
    check("t4 pc after",   pc16, 55);

    // 5: AM=A+1 with A=5, then reset in the middle of a write
    exec16(16'd5);
    i16 = c16(0, C_APLUS1, D_A | D_M, J_NO);
    #1;
    check("t5 addrM pre", addr16, 5);
    step();
    check("t5 writeM", wM16,   1);
    check("t5 outM",   outM16, 6);
    check("t5 addrM",  addr16, 5);
    step();                            // write completes, A is now 6
    check("t5 write done", wM16,   0);
    check("t5 A=6",        addr16, 6);
    step();                            // AM=A+1 again, A=6
    check("t5 writeM 2", wM16,   1);
    check("t5 outM 2",   outM16, 7);
    rdy16 = 1'b0;
    step();
    check("t5 stuck write", wM16, 1);
    rst16 = 1'b1;
    step();
    check("t5 rst writeM",  wM16,      0);
    check("t5 rst pc",      pc16,      0);
    check("t5 rst instret", instret16, 0);
    check("t5 rst retire",  ret16,     0);
    rst16 = 1'b0;

    // instret wraps at 2^16
    i16 = 16'd1; iv16 = 1'b1; rdy16 = 1'b1;
    repeat (65535) step();
    check("wrap max",  instret16, 16'hFFFF);
    step();
    check("wrap zero", instret16, 0);
    check("wrap retire", ret16, 1);
    iv16 = 1'b0;

    // 6: WIDTH=32
    step();
    check("w32 rst pc", pc32, 0);
    rst32 = 1'b0;
    exec32(32'h4000_0000);
    exec32(c32(0, C_A, D_D, J_NO));
    exec32(c32(0, C_DPLUSA, D_D, J_NO));
    exec32(c32(0, C_D, D_M, J_NO));
    check("w32 D",      outM32, 32'h8000_0000);
    check("w32 addrM",  addr32, 31'h4000_0000);
    check("w32 writeM", wM32,   1);
    step();
    check("w32 write done", wM32, 0);
    exec32(c32(0, C_D, D_NONE, J_LT));
    check("w32 JLT",     pc32,      31'h4000_0000);
    check("w32 instret", instret32, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ws.md
Name: hack_cpu_ws

Overview:
- Parametrised next-generation Hack CPU core: generic data width, wait-state memory handshake on data reads/writes, instruction-valid fetch stall, retired-instruction counter.
- Sits between instruction ROM and data RAM/MMIO in the ch05 computer.
- Replaces the single-cycle CPU wherever memory or fetch can stall.

Parameters:
- WIDTH, 16, data/instruction width (min 16); ADDR_W = WIDTH-1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- I  in  WIDTH  instruction at pc
- instr_valid  in  1  I is valid this cycle
- inM  in  WIDTH  data read from addressM
- mem_ready  in  1  data memory completes the current read/write this cycle
- outM  out  WIDTH  write data (registered)
- writeM  out  1  write request (registered)
- readM  out  1  read request (combinational)
- addressM  out  ADDR_W  data address
- pc  out  ADDR_W  fetch address (registered)
- retire  out  1  one-cycle pulse per committed instruction
- instret  out  WIDTH  count of committed instructions, wraps

Behaviour:
- Reset is synchronous active-high; one clock domain (clock).
- Reset values: A=0, D=0, pc=RESET_PC, state=EXEC, outM=0, writeM=0, retire=0, instret=0.
- Decode:
  - I[WIDTH-1]=0: A-instruction, A<=I[WIDTH-2:0] zero-extended.
  - Otherwise C-instruction, fields in I[12:0]: a=I[12], c=I[11:6] (zx nx zy ny f no), d=I[5:3] (A,D,M), j=I[2:0] (lt,eq,gt).
  - Bits I[WIDTH-2:13] are ignored.
- ALU: standard Hack function, WIDTH-bit two's complement, carry discarded. zr = result==0; ng = result[WIDTH-1].
- State EXEC:
  - instr_valid=0: nothing commits; pc and registers hold; readM=0.
  - C-instruction with a=1: readM=1, addressM=A.
  - If mem_ready=0, stall; nothing commits.
  - If mem_ready=1, commit using inM in the same cycle.
  - Commit, all in one edge:
    - Destinations A/D are written.
    - pc <= jump ? A[ADDR_W-1:0] : pc+1 (mod 2^ADDR_W).
    - retire<=1, instret+=1.
    - Jump uses the pre-update A and the ALU flags; j=111 is unconditional.
  - If d[M]=1 at commit: outM<=alu result, addr_q<=pre-update A, writeM<=1, state<=WRITE.
- State WRITE:
  - writeM=1, addressM=addr_q, readM=0.
  - The instruction already committed, so pc holds and I is not consumed.
  - mem_ready=1: writeM<=0, state<=EXEC. The next instruction is decoded in the following cycle.
- addressM = A in EXEC, addr_q in WRITE.
- Instruction latency:
  - One cycle: no M access.
  - 1+wait cycles: M read.
  - Plus one cycle minimum for an M write (1+wait).
- AM=..., MD=...: addressM is the pre-update A; register writes land at commit.
- M=M+1: read completes in EXEC, write follows in WRITE.
- Reset mid-WRITE: write abandoned; writeM=0 from the next cycle; no partial state survives.
- retire and writeM are never asserted on the same cycle as reset.

Decomposition:
- Package hack_pkg holds:
  - Field-position constants (A_BIT=12, C_LSB=6, D_LSB=3).
  - State enum {EXEC, WRITE}.
  - Jump-condition helper function.
- Sub-module hack_alu #(WIDTH) holds the combinational ALU with zr/ng outputs.
- FSM, registers and counter stay in hack_cpu_ws.

Test Plan:
1. Program with instr_valid=1, mem_ready=1, WIDTH=16: @12345, D=A, @23456, D=A-D -> D=11111, pc=4, instret=4, writeM never 1.
2. D=0; D;JEQ with A=100 -> pc=100. D=-1 (0xFFFF); D;JGT -> pc=prev+1. D;JLT -> pc=A.
3. A=7, D=M with mem_ready low for 3 cycles, inM=42 -> readM=1 for 4 cycles; D=42 on the 4th edge; pc advances once; retire single pulse.
4. A=7, M=M+1, inM=9, write ready after 2 wait cycles -> writeM=1 for 3 cycles, addressM=7, outM=10; pc advances on the read commit only.
5. AM=A+1 with A=5 -> addressM=5, outM=6, A=6 afterwards. Reset asserted mid-WRITE -> writeM=0 next cycle, pc=RESET_PC, instret=0.
6. WIDTH=32 instance; @0x40000000, D=A, D=D+A -> D=0x80000000. D;JLT taken; instret wrap at 0xFFFFFFFF -> 0.
